malloc_alloc_ctrl: RTL and testbench

// Allocation controller for the gsm_switch buffer-cell free bitmap held in malloc_core_infer (1 bit/cell, 1 = in use).

---
 rtl/malloc_alloc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_malloc_alloc_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/malloc_alloc_ctrl.sv
// Buffer-cell allocation controller: clears the free bitmap after reset, then serves
// next-fit allocations and double-free-checked releases against the bitmap's port B.
module malloc_alloc_ctrl #(
    parameter int DWIDTH_A = 4,
    parameter int AWIDTH_A = 9,
    parameter int AWIDTH_B = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                init_done,
    input  logic                alloc_req,
    output logic                alloc_gnt,
    output logic                alloc_fail,
    output logic [AWIDTH_B-1:0] alloc_addr,
    input  logic                free_req,
    input  logic [AWIDTH_B-1:0] free_addr,
    output logic                free_ack,
    output logic                free_err,
    output logic [AWIDTH_B:0]   free_count,
    output logic                mem_wea,
    output logic [AWIDTH_A-1:0] mem_addra,
    output logic [DWIDTH_A-1:0] mem_dina,
    output logic                mem_web,
    output logic [AWIDTH_B-1:0] mem_addrb,
    output logic                mem_dinb,
    input  logic [DWIDTH_A-1:0] mem_doutb
);

    localparam int LW = AWIDTH_B - AWIDTH_A;
    localparam logic [AWIDTH_B:0]   NCELL    = {1'b1, {AWIDTH_B{1'b0}}};
    localparam logic [AWIDTH_B:0]   CNT_ONE  = {{AWIDTH_B{1'b0}}, 1'b1};
    localparam logic [AWIDTH_B-1:0] CELL_ONE = {{(AWIDTH_B-1){1'b0}}, 1'b1};
    localparam logic [AWIDTH_A-1:0] WORD_ONE = {{(AWIDTH_A-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_FCHK,
        S_SCAN,
        S_MARK,
        S_AFAIL
    } state_t;

    state_t              state;
    logic [AWIDTH_B-1:0] ptr;
    logic [AWIDTH_B-1:0] scan_addr;
    logic [AWIDTH_B-1:0] checked;
    logic [LW-1:0]       lane_sel;
    logic                rd_bit;

    assign mem_dina = '0;

    // The bit read back always belongs to the address driven in the previous cycle.
    always_comb begin
        lane_sel = (state == S_FCHK) ? free_addr[LW-1:0] : scan_addr[LW-1:0];
        rd_bit   = mem_doutb[lane_sel];
    end

    always_comb begin
        mem_web    = 1'b0;
        mem_addrb  = ptr;
        mem_dinb   = 1'b0;
        alloc_gnt  = 1'b0;
        alloc_fail = 1'b0;
        free_ack   = 1'b0;
        free_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (free_req)
                    mem_addrb = free_addr;
            end
            S_FCHK: begin
                mem_addrb = free_addr;
                mem_web   = rd_bit;
                free_ack  = 1'b1;
                free_err  = ~rd_bit;
            end
            S_SCAN: begin
                mem_addrb = scan_addr + CELL_ONE;
            end
            S_MARK: begin
                mem_addrb = alloc_addr;
                mem_web   = 1'b1;
                mem_dinb  = 1'b1;
                alloc_gnt = 1'b1;
            end
            S_AFAIL: begin
                alloc_fail = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            ptr        <= '0;
            scan_addr  <= '0;
            checked    <= '0;
            free_count <= '0;
            alloc_addr <= '0;
            init_done  <= 1'b0;
            mem_wea    <= 1'b0;
            mem_addra  <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (!mem_wea) begin
                        mem_wea   <= 1'b1;
                        mem_addra <= '0;
                    end else if (mem_addra == '1) begin
                        mem_wea    <= 1'b0;
                        init_done  <= 1'b1;
                        free_count <= NCELL;
                        state      <= S_IDLE;
                    end else begin
                        mem_addra <= mem_addra + WORD_ONE;
                    end
                end
                S_IDLE: begin
                    if (free_req) begin
                        state <= S_FCHK;
                    end else if (alloc_req) begin
                        if (free_count == '0) begin
                            state <= S_AFAIL;
                        end else begin
                            state     <= S_SCAN;
                            scan_addr <= ptr;
                            checked   <= '0;
                        end
                    end
                end
                S_FCHK: begin
                    if (rd_bit && free_count != NCELL)
                        free_count <= free_count + CNT_ONE;
                    state <= S_IDLE;
                end
                S_SCAN: begin
                    // A full lap without a clear bit means the count and bitmap disagree.
                    if (!rd_bit) begin
                        alloc_addr <= scan_addr;
                        state      <= S_MARK;
                    end else if (checked == '1) begin
                        state <= S_AFAIL;
                    end else begin
                        checked   <= checked + CELL_ONE;
                        scan_addr <= scan_addr + CELL_ONE;
                    end
                end
                S_MARK: begin
                    if (free_count != '0)
                        free_count <= free_count - CNT_ONE;
                    ptr   <= alloc_addr + CELL_ONE;
                    state <= S_IDLE;
                end
                S_AFAIL: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_malloc_alloc_ctrl.sv
// Scoreboard bench for malloc_alloc_ctrl with a behavioural bitmap memory behind ports A/B.
module tb_malloc_alloc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done;
    logic        alloc_req = 1'b0;
    logic        alloc_gnt;
    logic        alloc_fail;
    logic [10:0] alloc_addr;
    logic        free_req = 1'b0;
    logic [10:0] free_addr = '0;
    logic        free_ack;
    logic        free_err;
    logic [11:0] free_count;
    logic        mem_wea;
    logic [8:0]  mem_addra;
    logic [3:0]  mem_dina;
    logic        mem_web;
    logic [10:0] mem_addrb;
    logic        mem_dinb;
    logic [3:0]  mem_doutb = '0;

    malloc_alloc_ctrl #(.DWIDTH_A(4), .AWIDTH_A(9), .AWIDTH_B(11)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_fail(alloc_fail), .alloc_addr(alloc_addr),
        .free_req(free_req), .free_addr(free_addr), .free_ack(free_ack), .free_err(free_err),
        .free_count(free_count),
        .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
        .mem_web(mem_web), .mem_addrb(mem_addrb), .mem_dinb(mem_dinb), .mem_doutb(mem_doutb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bitmap core: word write on A, bit write plus word read (1-cycle latency) on B.
    logic [3:0] bm [0:511];
    always @(posedge clk) begin
        if (mem_wea) bm[mem_addra] <= mem_dina;
        if (mem_web) bm[mem_addrb[10:2]][mem_addrb[1:0]] <= mem_dinb;
        mem_doutb <= bm[mem_addrb[10:2]];
    end

    typedef struct {
        int kind;   // 0 gnt, 1 fail, 2 ack
        int addr;
        int err;
        int cyc;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int wea_cnt = 0;
    int wea_bad = 0;
    int web_bad = 0;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            int   kind;
            if (mem_web && !(alloc_gnt || (free_ack && !free_err))) web_bad++;
            if (mem_wea) begin
                if (int'(mem_addra) != wea_cnt || mem_dina != 4'd0) wea_bad++;
                wea_cnt++;
            end
            if (alloc_gnt || alloc_fail || free_ack) begin
                kind = alloc_gnt ? 0 : (alloc_fail ? 1 : 2);
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required none", kind, cyc);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", kind, e.kind);
                    chk("pulse_cycle", cyc, e.cyc);
                    if (kind == 0) chk("alloc_addr", int'(alloc_addr), e.addr);
                    if (kind == 2) chk("free_err", int'(free_err), e.err);
                end
            end
        end
    end

    task automatic wait_alloc_done();
        int n;
        for (n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (alloc_gnt || alloc_fail) break;
        end
        if (n == 5000) chk("alloc_timeout", 1, 0);
    endtask

    task automatic wait_free_done();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (free_ack) break;
        end
        if (n == 100) chk("free_timeout", 1, 0);
    endtask

    task automatic do_alloc(input int kind, input int addr, input int nskip);
        exp_t e;
        @(posedge clk); #1;
        alloc_req = 1'b1;
        e.kind = kind; e.addr = addr; e.err = 0;
        e.cyc = (kind == 0) ? cyc + 2 + nskip : cyc + 1;
        q.push_back(e);
        wait_alloc_done();
        @(posedge clk); #1;
        alloc_req = 1'b0;
    endtask

    task automatic do_free(input int addr, input int err);
        exp_t e;
        @(posedge clk); #1;
        free_addr = 11'(addr);
        free_req  = 1'b1;
        e.kind = 2; e.addr = 0; e.err = err; e.cyc = cyc + 1;
        q.push_back(e);
        wait_free_done();
        @(posedge clk); #1;
        free_req = 1'b0;
    endtask

    task automatic check_reset();
        @(negedge clk);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_free_count", int'(free_count), 0);
        chk("rst_mem_wea", int'(mem_wea), 0);
        chk("rst_mem_web", int'(mem_web), 0);
        chk("rst_pulses", int'({alloc_gnt, alloc_fail, free_ack, free_err}), 0);
        chk("rst_alloc_addr", int'(alloc_addr), 0);
    endtask

    task automatic wait_init();
        int n;
        for (n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (init_done) break;
        end
        if (n == 1000) chk("init_timeout", 1, 0);
        chk("init_wea_cycles", wea_cnt, 512);
        chk("init_wea_seq", wea_bad, 0);
        chk("init_free_count", int'(free_count), 2048);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        check_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init();

        // Empty map: consecutive cells from ptr 0
        do_alloc(0, 0, 0);
        do_alloc(0, 1, 0);
        do_alloc(0, 2, 0);
        chk("count_after_3", int'(free_count), 2045);

        do_free(1, 0);
        chk("count_after_free", int'(free_count), 2046);
        do_free(1, 1);
        chk("count_after_dfree", int'(free_count), 2046);
        do_alloc(0, 3, 0);
        chk("count_nextfit", int'(free_count), 2045);

        for (int i = 4; i <= 2047; i++) do_alloc(0, i, 0);
        chk("count_fill", int'(free_count), 1);
        do_alloc(0, 1, 1);
        chk("count_full", int'(free_count), 0);

        do_free(2046, 0);
        do_alloc(0, 2046, 2044);
        do_free(0, 0);
        do_alloc(0, 0, 1);            // scan crosses 2047 -> 0
        chk("count_full2", int'(free_count), 0);

        do_alloc(1, 0, 0);
        chk("count_after_fail", int'(free_count), 0);

        // Simultaneous free and alloc: free wins, alloc follows
        @(posedge clk); #1;
        free_addr = 11'd5;
        free_req  = 1'b1;
        alloc_req = 1'b1;
        e.kind = 2; e.addr = 0; e.err = 0; e.cyc = cyc + 1;
        q.push_back(e);
        e.kind = 0; e.addr = 5; e.err = 0; e.cyc = cyc + 8;
        q.push_back(e);
        wait_free_done();
        @(posedge clk); #1;
        free_req = 1'b0;
        wait_alloc_done();
        @(posedge clk); #1;
        alloc_req = 1'b0;
        chk("count_simul", int'(free_count), 0);

        // Reset in the middle of a long scan
        do_free(1000, 0);
        @(posedge clk); #1;
        alloc_req = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        alloc_req = 1'b0;
        wea_cnt   = 0;
        wea_bad   = 0;
        check_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init();
        do_alloc(0, 0, 0);
        chk("count_post_reset", int'(free_count), 2047);

        repeat (3) @(posedge clk);
        chk("web_outside_write", web_bad, 0);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
